// File: rtl/rca_operand_loader.sv
// Serial-to-parallel operand feeder for the four-operand ripple-carry adder, with F-valid tracking.
// Optional group counter on grp_count is built when RCA_LOADER_STATS_EN is defined.
module rca_operand_loader #(
    parameter int W   = 4,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b,
    output logic [W-1:0] out_c,
    output logic [W-1:0] out_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         f_valid
`ifdef RCA_LOADER_STATS_EN
    ,
    output logic [15:0]  grp_count
`endif
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t         state, state_nxt;
    logic [1:0]     slot;
    logic [W-1:0]   stg [4];
    logic [W-1:0]   grp [4];
    logic [LAT-1:0] lat_sr;
    logic           accept, fire, complete, load_grp, load_stg;

    assign in_ready = rst_n & (state == FILL);
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;
    assign complete = accept & ((slot == 2'd3) | in_last);
    assign load_grp = (state == FILL) & complete & (~out_valid | fire);
    assign load_stg = (state == HOLD) & fire;
    assign f_valid  = lat_sr[LAT-1];

    // Completed group as it would stand after this accept; slots beyond the current word are zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            grp[i] = '0;
            if (2'(i) < slot)
                grp[i] = stg[i];
            else if (2'(i) == slot)
                grp[i] = in_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (complete && out_valid && !fire) state_nxt = HOLD;
            HOLD: if (fire) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) stg[i] <= '0;
        end else begin
            if (accept) begin
                if (complete) begin
                    slot <= '0;
                    // Output register busy: park the finished group in staging until it drains.
                    if (!load_grp)
                        for (int i = 0; i < 4; i++) stg[i] <= grp[i];
                end else begin
                    stg[slot] <= in_data;
                    slot      <= slot + 2'd1;
                end
            end
            if (load_grp) begin
                out_a     <= grp[0];
                out_b     <= grp[1];
                out_c     <= grp[2];
                out_d     <= grp[3];
                out_valid <= 1'b1;
            end else if (load_stg) begin
                out_a     <= stg[0];
                out_b     <= stg[1];
                out_c     <= stg[2];
                out_d     <= stg[3];
                out_valid <= 1'b1;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_sr <= '0;
        end else begin
            lat_sr[0] <= fire;
            for (int i = 1; i < LAT; i++) lat_sr[i] <= lat_sr[i-1];
        end
    end

`ifdef RCA_LOADER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            grp_count <= '0;
        else if (fire)
            grp_count <= grp_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rca_operand_loader.sv
// Scoreboard bench for rca_operand_loader: a word-level model pushes expected groups, a monitor pops on fire.
// Builds with or without RCA_LOADER_STATS_EN.
module tb_rca_operand_loader;

    localparam int W   = 4;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_a, out_b, out_c, out_d;
    logic         out_valid;
    logic         out_ready;
    logic         f_valid;
`ifdef RCA_LOADER_STATS_EN
    logic [15:0]  grp_count;
`endif

    rca_operand_loader #(.W(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_valid   (f_valid)
`ifdef RCA_LOADER_STATS_EN
        ,
        .grp_count (grp_count)
`endif
    );

    always #5 clk = ~clk;

    int               vec_cnt = 0;
    int               err_cnt = 0;
    logic [4*W-1:0]   sbq[$];
    int               mdl_slot = 0;
    logic [W-1:0]     mdl_w[4];
    int               cyc = 0;
    int               last_fire = -1;
    bit               chk_space = 1'b0;
    int               fire_total = 0;
    logic [LAT-1:0]   fh = '0;

    // Reference packing: stage words, emit a zero-padded group on slot 3 or in_last.
    task automatic model_accept(input logic [W-1:0] d, input logic last);
        mdl_w[mdl_slot] = d;
        if (last || mdl_slot == 3) begin
            for (int i = mdl_slot + 1; i < 4; i++) mdl_w[i] = '0;
            sbq.push_back({mdl_w[0], mdl_w[1], mdl_w[2], mdl_w[3]});
            mdl_slot = 0;
            for (int i = 0; i < 4; i++) mdl_w[i] = '0;
        end else begin
            mdl_slot++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the word was taken.
    task automatic send_word(input logic [W-1:0] d, input logic last, output int waited);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        #1;
        while (!in_ready && waited < 40) begin
            @(negedge clk); #1;
            waited++;
        end
        vec_cnt++;
        if (!in_ready) begin
            err_cnt++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            model_accept(d, last);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vec_cnt++;
        if (sbq.size() != 0) begin
            err_cnt++;
            $display("FAIL %s_drain: %0d groups pending, required 0", tag, sbq.size());
        end
    endtask

    // Monitor samples late in the low phase, after the testbench has driven its inputs.
    initial begin
        logic [4*W-1:0] exp;
        forever begin
            @(negedge clk); #3;
            cyc++;
            if (!rst_n) begin
                fh = '0;
                fire_total = 0;
                last_fire = -1;
            end else begin
                vec_cnt++;
                if (f_valid !== fh[LAT-1]) begin
                    err_cnt++;
                    $display("FAIL f_valid: got %0b required %0b at cycle %0d", f_valid, fh[LAT-1], cyc);
                end
                fh = {fh[LAT-2:0], (out_valid & out_ready)};
                if (out_valid && out_ready) begin
                    fire_total++;
                    vec_cnt++;
                    if (sbq.size() == 0) begin
                        err_cnt++;
                        $display("FAIL unexpected_group: got %h, none pending", {out_a, out_b, out_c, out_d});
                    end else begin
                        exp = sbq.pop_front();
                        if ({out_a, out_b, out_c, out_d} !== exp) begin
                            err_cnt++;
                            $display("FAIL group: got %h required %h", {out_a, out_b, out_c, out_d}, exp);
                        end
                    end
                    if (chk_space && last_fire >= 0) begin
                        vec_cnt++;
                        if (cyc - last_fire != 4) begin
                            err_cnt++;
                            $display("FAIL spacing: got %0d cycles required 4", cyc - last_fire);
                        end
                    end
                    last_fire = cyc;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vec_cnt++;
        if ({out_a, out_b, out_c, out_d, out_valid, f_valid, in_ready} !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: got %h required 0", {out_a, out_b, out_c, out_d, out_valid, f_valid, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL ready_after_reset: got %0b required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        int w;
        logic [W-1:0] v[4] = '{4'd3, 4'd5, 4'd3, 4'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(v[i], 1'b0, w);
        in_valid = 1'b0;
        #1;
        vec_cnt++;
        if ({out_valid, out_a, out_b, out_c, out_d} !== {1'b1, 16'h3530}) begin
            err_cnt++;
            $display("FAIL single_out: got %h required %h", {out_valid, out_a, out_b, out_c, out_d}, {1'b1, 16'h3530});
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({out_valid, f_valid} !== 2'b00) begin
            err_cnt++;
            $display("FAIL single_after: got %b required 00", {out_valid, f_valid});
        end
        @(negedge clk); #1;
        vec_cnt++;
        if (f_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL single_fvalid: got %0b required 1", f_valid);
        end
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        int w, wsum;
        logic [W-1:0] v[16] = '{4'd3, 4'd8, 4'd3, 4'd2, 4'd10, 4'd5, 4'd1, 4'd1,
                                4'd7, 4'd3, 4'd8, 4'd4, 4'd10, 4'd5, 4'd5, 4'd1};
        out_ready = 1'b1;
        last_fire = -1;
        chk_space = 1'b1;
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            send_word(v[i], 1'b0, w);
            wsum += w;
        end
        in_valid = 1'b0;
        vec_cnt++;
        if (wsum != 0) begin
            err_cnt++;
            $display("FAIL b2b_ready: stalled %0d cycles required 0", wsum);
        end
        wait_drain("b2b");
        chk_space = 1'b0;
    endtask

    task automatic test_hold();
        int w;
        logic [W-1:0] v[8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd8, 4'd7, 4'd6};
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(v[i], 1'b0, w);
        in_valid = 1'b0;
        repeat (3) begin
            #1;
            vec_cnt++;
            if ({in_ready, out_valid, out_a, out_b, out_c, out_d} !== {2'b01, 16'h1234}) begin
                err_cnt++;
                $display("FAIL hold_state: got %h required %h", {in_ready, out_valid, out_a, out_b, out_c, out_d}, {2'b01, 16'h1234});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk); #1;
        vec_cnt++;
        if ({in_ready, out_valid, out_a, out_b, out_c, out_d} !== {2'b11, 16'h9876}) begin
            err_cnt++;
            $display("FAIL hold_release: got %h required %h", {in_ready, out_valid, out_a, out_b, out_c, out_d}, {2'b11, 16'h9876});
        end
        wait_drain("hold");
    endtask

    task automatic test_last();
        int w;
        out_ready = 1'b1;
        send_word(4'd10, 1'b0, w);
        send_word(4'd5, 1'b1, w);
        in_valid = 1'b0;
        in_last  = 1'b1;
        @(negedge clk);
        send_word(4'd7, 1'b0, w);
        send_word(4'd8, 1'b0, w);
        send_word(4'd9, 1'b0, w);
        send_word(4'd6, 1'b1, w);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_drain("last");
    endtask

    task automatic test_mid_reset();
        int w;
        out_ready = 1'b1;
        send_word(4'd12, 1'b0, w);
        send_word(4'd13, 1'b0, w);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({out_a, out_b, out_c, out_d, out_valid, f_valid, in_ready} !== '0) begin
            err_cnt++;
            $display("FAIL midreset_outputs: got %h required 0", {out_a, out_b, out_c, out_d, out_valid, f_valid, in_ready});
        end
        mdl_slot = 0;
        for (int i = 0; i < 4; i++) mdl_w[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(4'd12, 1'b0, w);
        send_word(4'd13, 1'b0, w);
        send_word(4'd2, 1'b0, w);
        send_word(4'd4, 1'b0, w);
        in_valid = 1'b0;
        #1;
        vec_cnt++;
        if ({out_a, out_b, out_c, out_d} !== 16'hCD24) begin
            err_cnt++;
            $display("FAIL midreset_group: got %h required cd24", {out_a, out_b, out_c, out_d});
        end
        wait_drain("midreset");
    endtask

`ifdef RCA_LOADER_STATS_EN
    task automatic test_stats();
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++;
        if (grp_count !== fire_total[15:0]) begin
            err_cnt++;
            $display("FAIL grp_count: got %0d required %0d", grp_count, fire_total);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) mdl_w[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_last();
        test_mid_reset();
`ifdef RCA_LOADER_STATS_EN
        test_stats();
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
